// File: rtl/crc_frame_engine.sv
// Framed CRC checker: accumulates a CRC over the enabled byte lanes of each frame
// and presents the final value plus a match flag against the CRC carried on the eof beat.
module crc_frame_engine #(
   parameter int unsigned      DATA_W  = 32,
   parameter int unsigned      CRC_W   = 16,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
   parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b0}},
   parameter logic [CRC_W-1:0] XOR_OUT = {CRC_W{1'b0}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   input  logic [DATA_W/8-1:0] s_keep,
   input  logic                s_sof,
   input  logic                s_eof,
   input  logic [CRC_W-1:0]    s_crc,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [CRC_W-1:0]    m_crc,
   output logic                m_match,
   output logic [15:0]         err_count,
   output logic                drop_pulse,
   output logic                abort_pulse
);

   localparam int unsigned LANES = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   // Bit-serial MSB-first CRC over enabled lanes, MSB lane first; disabled lanes are skipped.
   function automatic logic [CRC_W-1:0] crc_beat(
      input logic [CRC_W-1:0]  crc_in,
      input logic [DATA_W-1:0] data,
      input logic [LANES-1:0]  keep
   );
      logic [CRC_W-1:0] c;
      logic [CRC_W-1:0] nxt;
      logic             fb;
      c = crc_in;
      for (int lane = LANES - 1; lane >= 0; lane--) begin
         for (int b = 7; b >= 0; b--) begin
            fb  = c[CRC_W-1] ^ data[8*lane + b];
            nxt = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
            c   = keep[lane] ? nxt : c;
         end
      end
      return c;
   endfunction

   state_t            state_q, state_d;
   logic [CRC_W-1:0]  crc_q, crc_d;
   logic              ready_q, ready_d;
   logic              m_valid_q, m_valid_d;
   logic [CRC_W-1:0]  m_crc_q, m_crc_d;
   logic              m_match_q, m_match_d;
   logic [15:0]       err_q, err_d;
   logic              drop_q, drop_d;
   logic              abort_q, abort_d;

   logic              accept_s;
   logic              result_entry_s;
   logic [CRC_W-1:0]  beat_crc_s;
   logic [CRC_W-1:0]  final_crc_s;

   assign accept_s    = s_valid & ready_q;
   assign beat_crc_s  = crc_beat(s_sof ? INIT : crc_q, s_data, s_keep);
   assign final_crc_s = beat_crc_s ^ XOR_OUT;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         crc_q     <= INIT;
         ready_q   <= 1'b0;
         m_valid_q <= 1'b0;
         m_crc_q   <= {CRC_W{1'b0}};
         m_match_q <= 1'b0;
         err_q     <= 16'h0000;
         drop_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         ready_q   <= ready_d;
         m_valid_q <= m_valid_d;
         m_crc_q   <= m_crc_d;
         m_match_q <= m_match_d;
         err_q     <= err_d;
         drop_q    <= drop_d;
         abort_q   <= abort_d;
      end
   end

   // A sof beat always reseeds, whether it opens a frame or aborts the current one.
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && s_sof) begin
               crc_d   = beat_crc_s;
               state_d = s_eof ? ST_RESULT : ST_ACTIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (accept_s) begin
               crc_d   = beat_crc_s;
               state_d = s_eof ? ST_RESULT : ST_ACTIVE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_RESULT: begin
            if (m_valid_q && m_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESULT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            crc_d   = INIT;
         end
      endcase
   end

   always_comb begin
      result_entry_s = (state_q != ST_RESULT) && (state_d == ST_RESULT);
      ready_d        = (state_d != ST_RESULT);
      m_valid_d      = (state_d == ST_RESULT);
      m_crc_d        = result_entry_s ? final_crc_s : m_crc_q;
      m_match_d      = result_entry_s ? (final_crc_s == s_crc) : m_match_q;
      if (result_entry_s && (final_crc_s != s_crc) && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'h0001;
      end else begin
         err_d = err_q;
      end
      drop_d  = accept_s && (state_q == ST_IDLE) && !s_sof;
      abort_d = accept_s && (state_q == ST_ACTIVE) && s_sof;
   end

   assign s_ready     = ready_q;
   assign m_valid     = m_valid_q;
   assign m_crc       = m_crc_q;
   assign m_match     = m_match_q;
   assign err_count   = err_q;
   assign drop_pulse  = drop_q;
   assign abort_pulse = abort_q;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Scoreboard bench for crc_frame_engine: two instances (seed 0 and seed FFFF) share stimulus
// and each result handshake is checked against a byte-wise reference CRC model.
`timescale 1ns/1ps
module tb_crc_frame_engine;

   typedef struct packed {
      logic [15:0] crc;
      logic        match;
      logic [15:0] err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic [31:0] s_data;
   logic [3:0]  s_keep;
   logic        s_sof;
   logic        s_eof;
   logic [15:0] s_crc;
   logic        m_ready;

   logic        u0_s_ready, u0_m_valid, u0_m_match, u0_drop, u0_abort;
   logic [15:0] u0_m_crc, u0_err;
   logic        u1_s_ready, u1_m_valid, u1_m_match, u1_drop, u1_abort;
   logic [15:0] u1_m_crc, u1_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        e0, e1;
   logic [15:0] mc0, mc1, merr0, merr1;
   logic        mactive;

   always #5 clk = ~clk;

   crc_frame_engine #(.DATA_W(32), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000)) u0 (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(u0_s_ready), .s_data(s_data),
      .s_keep(s_keep), .s_sof(s_sof), .s_eof(s_eof), .s_crc(s_crc), .m_valid(u0_m_valid),
      .m_ready(m_ready), .m_crc(u0_m_crc), .m_match(u0_m_match), .err_count(u0_err),
      .drop_pulse(u0_drop), .abort_pulse(u0_abort));

   crc_frame_engine #(.DATA_W(32), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)) u1 (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(u1_s_ready), .s_data(s_data),
      .s_keep(s_keep), .s_sof(s_sof), .s_eof(s_eof), .s_crc(s_crc), .m_valid(u1_m_valid),
      .m_ready(m_ready), .m_crc(u1_m_crc), .m_match(u1_m_match), .err_count(u1_err),
      .drop_pulse(u1_drop), .abort_pulse(u1_abort));

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Byte-at-a-time CRC-CCITT reference over enabled lanes, MSB lane first.
   function automatic logic [15:0] model_beat(input logic [15:0] c_in, input logic [31:0] d, input logic [3:0] k);
      logic [15:0] c;
      logic [7:0]  by;
      c = c_in;
      for (int l = 3; l >= 0; l--) begin
         if (k[l]) begin
            by = d[8*l +: 8];
            c  = c ^ {by, 8'h00};
            for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return c;
   endfunction

   // Drive one beat, wait for acceptance, update the model and check the resulting pulses.
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic sof, input logic eof, input logic [15:0] sc);
      int   w;
      logic exp_drop, exp_abort;
      s_data = d; s_keep = k; s_sof = sof; s_eof = eof; s_crc = sc; s_valid = 1'b1;
      w = 0;
      while (!u0_s_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check_value("ready_wait", 32'(u0_s_ready), 32'd1);
      @(posedge clk);
      #1;
      s_valid   = 1'b0;
      exp_drop  = !mactive && !sof;
      exp_abort = mactive && sof;
      if (!exp_drop) begin
         if (sof) begin
            mc0 = 16'h0000;
            mc1 = 16'hFFFF;
         end
         mc0 = model_beat(mc0, d, k);
         mc1 = model_beat(mc1, d, k);
         if (eof) begin
            if (mc0 != sc && merr0 != 16'hFFFF) merr0 = merr0 + 16'd1;
            if (mc1 != sc && merr1 != 16'hFFFF) merr1 = merr1 + 16'd1;
            q0.push_back('{crc: mc0, match: (mc0 == sc), err: merr0});
            q1.push_back('{crc: mc1, match: (mc1 == sc), err: merr1});
            mactive = 1'b0;
         end else begin
            mactive = 1'b1;
         end
      end
      @(negedge clk);
      check_value("drop_pulse", 32'(u0_drop), 32'(exp_drop));
      check_value("abort_pulse", 32'(u0_abort), 32'(exp_abort));
      if (exp_drop) begin
         check_value("drop_no_result", 32'(u0_m_valid), 32'd0);
         check_value("drop_ready", 32'(u0_s_ready), 32'd1);
      end else if (eof) begin
         check_value("valid_latency", 32'(u0_m_valid), 32'd1);
         check_value("result_not_ready", 32'(u0_s_ready), 32'd0);
      end
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      reset = 1'b1; s_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_value("rst_ready", 32'(u0_s_ready), 32'd0);
      check_value("rst_valid", 32'(u0_m_valid), 32'd0);
      check_value("rst_crc0", 32'(u0_m_crc), 32'd0);
      check_value("rst_crc1", 32'(u1_m_crc), 32'd0);
      check_value("rst_match", 32'(u1_m_match), 32'd0);
      check_value("rst_err0", 32'(u0_err), 32'd0);
      check_value("rst_err1", 32'(u1_err), 32'd0);
      check_value("rst_drop", 32'(u0_drop), 32'd0);
      check_value("rst_abort", 32'(u0_abort), 32'd0);
      q0.delete(); q1.delete();
      merr0 = 16'h0000; merr1 = 16'h0000; mactive = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_value("post_rst_ready", 32'(u0_s_ready), 32'd1);
      check_value("post_rst_valid", 32'(u0_m_valid), 32'd0);
   endtask

   task automatic send_123456789(input logic with_empty, input logic [15:0] sc);
      send_beat(32'h31323334, 4'hF, 1'b1, 1'b0, sc);
      if (with_empty) send_beat(32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, sc);
      send_beat(32'h35363738, 4'hF, 1'b0, 1'b0, sc);
      send_beat(32'h39000000, 4'h8, 1'b0, 1'b1, sc);
   endtask

   // Scoreboard consumers: compare every result handshake against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && u0_m_valid && m_ready) begin
         if (q0.size() == 0) check_value("sb0_underflow", 32'(q0.size()), 32'd1);
         else begin
            e0 = q0.pop_front();
            check_value("sb0_crc", 32'(u0_m_crc), 32'(e0.crc));
            check_value("sb0_match", 32'(u0_m_match), 32'(e0.match));
            check_value("sb0_err", 32'(u0_err), 32'(e0.err));
         end
      end
      if (!reset && u1_m_valid && m_ready) begin
         if (q1.size() == 0) check_value("sb1_underflow", 32'(q1.size()), 32'd1);
         else begin
            e1 = q1.pop_front();
            check_value("sb1_crc", 32'(u1_m_crc), 32'(e1.crc));
            check_value("sb1_match", 32'(u1_m_match), 32'(e1.match));
            check_value("sb1_err", 32'(u1_err), 32'(e1.err));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = 32'h0; s_keep = 4'h0;
      s_sof = 1'b0; s_eof = 1'b0; s_crc = 16'h0; m_ready = 1'b1;
      mc0 = 16'h0000; mc1 = 16'hFFFF; merr0 = 16'h0000; merr1 = 16'h0000; mactive = 1'b0;
      reset_dut();

      // Known-answer "123456789" frame on both seeds.
      send_123456789(1'b0, 16'h31C3);
      check_value("kat_crc0", 32'(u0_m_crc), 32'h31C3);
      check_value("kat_match0", 32'(u0_m_match), 32'd1);
      check_value("kat_crc1", 32'(u1_m_crc), 32'h29B1);
      check_value("kat_match1", 32'(u1_m_match), 32'd0);
      check_value("kat_err1", 32'(u1_err), 32'd1);

      send_123456789(1'b0, 16'h0000);
      check_value("kat2_crc1", 32'(u1_m_crc), 32'h29B1);
      check_value("kat2_err0", 32'(u0_err), 32'd1);

      send_123456789(1'b1, 16'h31C3);
      check_value("empty_keep_crc0", 32'(u0_m_crc), 32'h31C3);

      // Backpressure: result must hold for five cycles with m_ready low.
      @(posedge clk); #1; m_ready = 1'b0;
      send_123456789(1'b0, 16'h31C3);
      repeat (5) begin
         @(negedge clk);
         check_value("bp_ready", 32'(u0_s_ready), 32'd0);
         check_value("bp_valid", 32'(u0_m_valid), 32'd1);
         check_value("bp_crc0", 32'(u0_m_crc), 32'h31C3);
         check_value("bp_crc1", 32'(u1_m_crc), 32'h29B1);
      end
      @(posedge clk); #1; m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_value("bp_release_valid", 32'(u0_m_valid), 32'd0);
      check_value("bp_release_ready", 32'(u0_s_ready), 32'd1);

      // Framing errors: stray beat in IDLE, then an sof restarting a frame.
      send_beat(32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 16'h0000);
      send_123456789(1'b0, 16'h31C3);
      check_value("after_drop_crc0", 32'(u0_m_crc), 32'h31C3);
      send_beat(32'hAAAAAAAA, 4'hF, 1'b1, 1'b0, 16'h0000);
      send_beat(32'h55555555, 4'h3, 1'b0, 1'b0, 16'h0000);
      send_123456789(1'b0, 16'h31C3);
      check_value("abort_crc0", 32'(u0_m_crc), 32'h31C3);
      check_value("abort_crc1", 32'(u1_m_crc), 32'h29B1);

      // Reset mid-frame, then reset while a result is pending.
      send_beat(32'h12345678, 4'hF, 1'b1, 1'b0, 16'h0000);
      reset_dut();
      send_123456789(1'b0, 16'h31C3);
      check_value("rst_mid_crc0", 32'(u0_m_crc), 32'h31C3);
      @(posedge clk); #1; m_ready = 1'b0;
      send_123456789(1'b0, 16'h0000);
      reset_dut();
      @(posedge clk); #1; m_ready = 1'b1;
      @(negedge clk);

      // Random frames through the scoreboard.
      for (int f = 0; f < 8; f++) begin
         int nb;
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++)
            send_beat($urandom, 4'($urandom_range(0, 15)), (b == 0), (b == nb - 1), 16'($urandom));
      end

      // Error counter saturation.
      for (int i = 0; i < 65540; i++) send_beat(32'h0, 4'h0, 1'b1, 1'b1, 16'h1234);
      check_value("sat_err0", 32'(u0_err), 32'hFFFF);
      check_value("sat_err1", 32'(u1_err), 32'hFFFF);
      send_beat(32'h0, 4'h0, 1'b1, 1'b1, 16'h1234);
      check_value("sat_nowrap", 32'(u0_err), 32'hFFFF);

      repeat (3) @(negedge clk);
      check_value("sb0_drained", 32'(q0.size()), 32'd0);
      check_value("sb1_drained", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/crc_frame_engine.md
CRC_FRAME_ENGINE -- requirements
Module: crc_frame_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 The block SHALL have parameter CRC_W, default 16, giving the CRC width in bits; legal values are 8 to 32.
REQ-003 The block SHALL have parameter POLY, default 16'h1021, giving the generator polynomial with the implicit top term omitted.
REQ-004 The block SHALL have parameter INIT, default 0, giving the CRC seed loaded at start of frame.
REQ-005 The block SHALL have parameter XOR_OUT, default 0, giving the value XORed into the final CRC.
REQ-006 The block SHALL have the following ports: reset synchronous, active-high; clock clk.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_data  in  DATA_W  beat data; first serial bit is s_data[DATA_W-1]
- s_keep  in  DATA_W/8  byte-lane enables; bit i covers s_data[8i+7:8i]
- s_sof  in  1  beat is the first of a frame
- s_eof  in  1  beat is the last of a frame
- s_crc  in  CRC_W  expected CRC, sampled on the eof beat
- m_valid  out  1  result valid
- m_ready  in  1  result consumed
- m_crc  out  CRC_W  final CRC (running CRC XOR XOR_OUT)
- m_match  out  1  m_crc equals the sampled s_crc
- err_count  out  16  count of mismatched frames, saturating
- drop_pulse  out  1  one-cycle pulse when a beat is discarded outside a frame
- abort_pulse  out  1  one-cycle pulse when a frame restarts on an sof

Function
REQ-007 Beat acceptance SHALL be s_valid & s_ready; no other input is qualified without it.
REQ-008 The FSM SHALL have three states, IDLE, ACTIVE and RESULT, with s_ready=1 in IDLE and ACTIVE and s_ready=0 in RESULT.
REQ-009 In IDLE, an accepted beat with s_sof=1 SHALL process data from seed INIT and go to ACTIVE, or to RESULT if s_eof=1 on the same beat.
REQ-010 In IDLE, an accepted beat with s_sof=0 SHALL be discarded, pulse drop_pulse for one cycle, and leave state and CRC unchanged.
REQ-011 In ACTIVE, an accepted beat with s_sof=1 SHALL reseed from INIT, process the beat, and pulse abort_pulse for one cycle.
REQ-012 In ACTIVE, an accepted beat with s_eof=1 SHALL go to RESULT.
REQ-013 Each accepted beat SHALL process only the enabled byte lanes, from MSB lane to LSB lane, MSB-first within each lane; disabled lanes are skipped rather than zero-filled.
REQ-014 A beat with s_keep all-zero SHALL leave the CRC unchanged but still act on its sof and eof flags.
REQ-015 The CRC update SHALL complete in one cycle per beat, with no throughput penalty: one beat per cycle.
REQ-016 The eof beat accepted in cycle N SHALL make m_valid=1 in cycle N+1, with m_crc and m_match stable while m_valid=1.
REQ-017 m_valid SHALL hold until m_valid & m_ready; on that handshake the block SHALL go to IDLE and drop m_valid the next cycle.
REQ-018 The first beat after a result handshake SHALL be acceptable in the cycle after the handshake.
REQ-019 On entry to RESULT with m_match=0, err_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-020 drop_pulse and abort_pulse SHALL be registered, asserted in the cycle after the triggering beat.

Reset
REQ-021 While reset=1 the block SHALL set the state to IDLE, the running CRC to INIT, m_valid=0, m_crc=0, m_match=0, err_count=0, drop_pulse=0 and abort_pulse=0.
REQ-022 While reset=1 the block SHALL hold s_ready=0, and s_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-023 Reset SHALL override every other event in the same cycle, including mid-frame and while in RESULT with m_valid=1; any pending result is lost.

Verification (defaults: DATA_W=32, CRC_W=16, POLY=16'h1021)
REQ-024 The bench SHALL cover single-frame check with INIT=0: beats 0x31323334 (sof), 0x35363738, then 0x39000000 with keep=4'b1000 and eof, s_crc=16'h31C3 -> m_crc=16'h31C3, m_match=1, m_valid one cycle after eof.
REQ-025 The bench SHALL cover the same frame with INIT=16'hFFFF and s_crc=16'h0000 -> m_crc=16'h29B1, m_match=0, err_count=1.
REQ-026 The bench SHALL cover a keep=4'b0000 beat inserted mid-frame in REQ-024 -> result unchanged at 16'h31C3.
REQ-027 The bench SHALL cover backpressure: hold m_ready=0 for 5 cycles after eof -> s_ready=0, m_crc and m_valid stable, then a handshake and IDLE.
REQ-028 The bench SHALL cover framing errors: a beat without sof in IDLE -> drop_pulse with no state change; sof mid-frame -> abort_pulse and the CRC of the new frame only.
REQ-029 The bench SHALL cover reset mid-frame and during RESULT, and 65536+ mismatched frames -> err_count saturating at 16'hFFFF with no wrap to 0.
